// File: rtl/pwm_dac_if.sv
// pwm_dac_if: sample request/response and PWM pin bundle between a producer and the DAC.
interface pwm_dac_if #(
  parameter int CODE_WIDTH = 14
);
  logic                  i_en;
  logic [CODE_WIDTH-1:0] i_code;
  logic                  o_next_sample;
  logic                  o_pwm;
  modport master (output i_en, output i_code, input o_next_sample, input o_pwm);
  modport slave  (input i_en, input i_code, output o_next_sample, output o_pwm);
endinterface

// File: rtl/pwm_dac.sv
// pwm_dac: noise-shaped PWM audio DAC; requests one sample per 2^PWM_BITS-cycle window and
// folds the truncated LSBs back into the next sample (first-order error feedback).
module pwm_dac #(
  parameter int CODE_WIDTH = 14,
  parameter int PWM_BITS   = 10
) (
  input logic     clk,
  input logic     rst,
  pwm_dac_if.slave bus
);
  localparam int L  = CODE_WIDTH - PWM_BITS;
  localparam int EL = (L > 0) ? L : 1;
  localparam logic [PWM_BITS-1:0] C_MAX = '1;
  localparam logic [PWM_BITS-1:0] C_REQ = PWM_BITS'((1 << PWM_BITS) - 3);
  logic [PWM_BITS-1:0] r_cnt, r_duty;
  logic [EL-1:0]       r_err;
  logic                r_pwm, r_ns;
  logic [CODE_WIDTH:0] w_sum;
  logic [EL-1:0]       w_err;
  logic                w_latch;
  // r_err never leaves zero when there are no fed-back LSBs, so the add stays harmless.
  always_comb begin
    w_sum   = {1'b0, bus.i_code} + (CODE_WIDTH+1)'(r_err);
    w_err   = (L > 0) ? w_sum[EL-1:0] : '0;
    w_latch = bus.i_en && (r_cnt == C_MAX);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_err  <= '0;
      r_pwm  <= 1'b0;
      r_ns   <= 1'b0;
    end else begin
      r_cnt <= bus.i_en ? r_cnt + PWM_BITS'(1) : '0;
      r_pwm <= bus.i_en && (r_cnt < r_duty);
      r_ns  <= bus.i_en && (r_cnt == C_REQ);
      if (w_latch) begin
        r_duty <= w_sum[CODE_WIDTH] ? C_MAX : w_sum[CODE_WIDTH-1:L];
        r_err  <= w_sum[CODE_WIDTH] ? '0 : w_err;
      end
    end
  end
  assign bus.o_pwm         = r_pwm;
  assign bus.o_next_sample = r_ns;
endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: randomized checks of pwm_dac against a window-level timeline model.
module tb_pwm_dac;
  localparam int CW   = 14;
  localparam int PB   = 10;
  localparam int W    = 1 << PB;
  localparam int L    = CW - PB;
  localparam int MASK = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_dac_if #(.CODE_WIDTH(CW)) bus ();
  pwm_dac #(.CODE_WIDTH(CW), .PWM_BITS(PB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int errors = 0;
  int checks = 0;
  int pos, duty_cur, duty_nxt, m_err, highs;
  int code_const;
  int prod_n, present, lat_idx;

  function automatic int f_sample(input int a);
    return (a * 1237 + 4096) & MASK;
  endfunction

  function automatic void model_reset();
    pos = 0; duty_cur = 0; duty_nxt = 0; m_err = 0; highs = 0;
  endfunction

  function automatic void model_latch(input int c);
    int s;
    s = c + m_err;
    if (s >= (1 << CW)) begin
      duty_nxt = W - 1;
      m_err = 0;
    end else begin
      duty_nxt = s >> L;
      m_err = s % (1 << L);
    end
  endfunction

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      logic e_ns, e_pwm;
      int mc, dc;
      e_ns  = (pos == W - 2);
      e_pwm = (pos >= 1) && (pos - 1 < duty_cur);
      checks++;
      if (bus.o_next_sample !== e_ns) begin
        errors++;
        $display("FAIL next_sample pos=%0d got=%b exp=%b", pos, bus.o_next_sample, e_ns);
      end
      checks++;
      if (bus.o_pwm !== e_pwm) begin
        errors++;
        $display("FAIL pwm pos=%0d duty=%0d got=%b exp=%b", pos, duty_cur, bus.o_pwm, e_pwm);
      end
      if (pos >= 1 && bus.o_pwm === 1'b1) highs++;
      if (mode == 2 && bus.o_next_sample === 1'b1) begin
        present = prod_n;
        prod_n++;
      end
      if (pos == W - 1) begin
        checks++;
        if (highs != duty_cur) begin
          errors++;
          $display("FAIL high_time got=%0d exp=%0d", highs, duty_cur);
        end
        highs = 0;
        if (mode == 0) begin
          mc = code_const; dc = code_const;
        end else if (mode == 1) begin
          mc = int'($urandom_range(0, MASK)); dc = mc;
        end else begin
          mc = f_sample(lat_idx); dc = f_sample(present);
          lat_idx++;
        end
        bus.i_code = CW'(dc);
        model_latch(mc);
      end else begin
        bus.i_code = CW'($urandom);
      end
      @(posedge clk);
      pos = (pos + 1) % W;
      if (pos == 0) begin
        duty_cur = duty_nxt;
        #1;
        checks++;
        if (int'(dut.r_err) != m_err) begin
          errors++;
          $display("FAIL err got=%0d exp=%0d", dut.r_err, m_err);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.i_en = 1'b0; bus.i_code = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_pwm !== 1'b0 || bus.o_next_sample !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b exp=00", bus.o_pwm, bus.o_next_sample);
    end
    rst = 1'b0; bus.i_en = 1'b1;
    model_reset();
    code_const = 'h3FFF;
    run(2 * W - 2, 0);
  endtask

  task automatic test_async_reset();
    checks++;
    if (bus.o_pwm !== 1'b1 || bus.o_next_sample !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got=%b%b exp=11", bus.o_pwm, bus.o_next_sample);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.o_pwm !== 1'b0 || bus.o_next_sample !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got=%b%b exp=00", bus.o_pwm, bus.o_next_sample);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    code_const = 'h2000;
    run(W + 8, 0);
  endtask

  task automatic test_midscale();
    code_const = 'h2000;
    run(3 * W, 0);
  endtask

  task automatic test_noise_shaping();
    code_const = 'h2008;
    run(4 * W, 0);
  endtask

  task automatic test_extremes();
    code_const = 'h0000;
    run(2 * W, 0);
    code_const = 'h3FFF;
    run(4 * W, 0);
  endtask

  task automatic test_enable_mid();
    run((300 - pos + W) % W, 1);
    bus.i_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (bus.o_pwm !== 1'b0 || bus.o_next_sample !== 1'b0 || dut.r_cnt !== '0) begin
        errors++;
        $display("FAIL en_low pwm=%b ns=%b cnt=%0d exp 0/0/0", bus.o_pwm, bus.o_next_sample, dut.r_cnt);
      end
      bus.i_code = CW'($urandom);
      @(negedge clk);
    end
    checks++;
    if (int'(dut.r_duty) != duty_cur || int'(dut.r_err) != m_err) begin
      errors++;
      $display("FAIL en_hold duty=%0d err=%0d exp %0d/%0d", dut.r_duty, dut.r_err, duty_cur, m_err);
    end
    bus.i_en = 1'b1;
    pos = 0; highs = 0; duty_nxt = duty_cur;
    run(2 * W, 1);
  endtask

  task automatic test_en_latch();
    run((W - 1 - pos + W) % W, 1);
    bus.i_code = CW'((duty_cur ^ (W / 2)) << L);
    bus.i_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (int'(dut.r_duty) != duty_cur || int'(dut.r_err) != m_err) begin
      errors++;
      $display("FAIL en_latch duty=%0d err=%0d exp %0d/%0d", dut.r_duty, dut.r_err, duty_cur, m_err);
    end
    bus.i_en = 1'b1;
    pos = 0; highs = 0; duty_nxt = duty_cur;
    run(W, 1);
  endtask

  task automatic test_random();
    run(6 * W, 1);
  endtask

  task automatic test_integration();
    prod_n = 0; present = 0; lat_idx = 0;
    run(20 * W, 2);
    checks++;
    if (prod_n != lat_idx) begin
      errors++;
      $display("FAIL request_count got=%0d exp=%0d", prod_n, lat_idx);
    end
  endtask

  initial begin
    bus.i_en = 1'b0;
    bus.i_code = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_async_reset();
    test_midscale();
    test_noise_shaping();
    test_extremes();
    test_enable_mid();
    test_en_latch();
    test_random();
    test_integration();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pwm_dac.md
# pwm_dac

Audio output stage that consumes the NCO sample stream. It generates a fixed-rate `next_sample` strobe and latches the resulting 14-bit offset-binary `code` once per PWM window. It reduces the code to PWM_BITS of duty with first-order error feedback (noise shaping) and drives a single-bit PWM pin. It sits between the `nco` (or a mixer of NCOs) and the board audio output.

## Interface
- CODE_WIDTH, 14, width of input sample; unsigned offset binary (0 = most negative, 2^(CODE_WIDTH-1) = midscale).
- PWM_BITS, 10, duty resolution; window length W = 2^PWM_BITS cycles; legal range 2..CODE_WIDTH.
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable; synchronous.
- code  input  CODE_WIDTH  sample from producer; must be valid the cycle after `next_sample`.
- next_sample  output  1  one-cycle request strobe to producer (registered).
- pwm  output  1  PWM output (registered).

## Operation
- Derived: L = CODE_WIDTH − PWM_BITS (LSBs fed back); MAX = W − 1.
- Registers: window counter `cnt` (PWM_BITS), duty `duty` (PWM_BITS), error `err` (L bits; absent when L = 0), `pwm`, `next_sample`.
- Reset (asynchronous): cnt = 0, duty = 0, err = 0, pwm = 0, next_sample = 0. All outputs are low immediately on rst assertion, independent of clk.
- en = 1: cnt increments every cycle and wraps MAX → 0.
- en = 0: cnt ← 0, pwm ← 0, next_sample ← 0. duty and err hold. This applies mid-window too, with no partial-window completion.
- Request: next_sample is high exactly during the cycle where cnt == MAX−1 (and en was 1 on the preceding edge). This gives exactly one pulse per W cycles.
- Latch: on the edge ending the cycle where cnt == MAX (en = 1):
  - Form sum = code + err, computed CODE_WIDTH+1 bits wide.
  - If sum[CODE_WIDTH] = 1 (overflow): duty ← MAX, err ← 0 (saturate).
  - Else: duty ← sum[CODE_WIDTH−1:L], err ← sum[L−1:0].
- The new duty governs the window that starts at cnt = 0.
- PWM: pwm ← en && (cnt < duty) on every edge. High-time per window is exactly duty cycles, range 0..MAX. A full-on window is never produced, so duty MAX gives MAX high cycles.
- Long-run average duty equals code / 2^L per window (error feedback).
- Simultaneous events:
  - rst dominates everything.
  - en falling on the latch cycle: the latch is suppressed because en = 0 takes priority.
  - A code change on cycles other than the one after next_sample is ignored.

## Timing
- Request→sample: code is sampled 1 cycle after the next_sample pulse. This matches `nco` updating its phase on the next_sample edge with a combinational LUT output.
- Sample→output: the new duty takes effect on the cycle cnt becomes 0. pwm reflects it one cycle later, because the pwm flop lags cnt by 1.
- Sample rate: f_clk / W. The next_sample period is exactly W cycles while en = 1.
- After en rises (cnt = 0), the first next_sample comes W−2 cycles later. The first window uses the held duty.
- After rst release with en = 1: the first next_sample comes at cnt = MAX−1. pwm stays 0 for the first window (duty = 0).
- No combinational path from any input to any output.

## Test plan
- Async reset: with en = 1 mid-window, pulse rst between clock edges. pwm and next_sample must drop to 0 without a clock edge. After release, the next_sample pulse is at cycle 1022 (W = 1024) and pwm stays 0 for the whole first window.
- Midscale: code = 0x2000 constant, defaults. next_sample period is 1024 cycles. From the second window on, pwm is high for 512 cycles per window and err stays 0.
- Noise shaping: code = 0x2008. Duty per window must alternate 512, 513, 512, 513… (err 8, 0, 8, 0). Average high-time is 512.5.
- Extremes:
  - code = 0x0000: pwm never high.
  - code = 0x3FFF: every window has high-time 1023, with err alternating 15 and 0; the overflow window saturates to 1023.
  - No glitch at the wrap.
- Enable mid-window: deassert en at cnt = 300. The next cycle shows cnt = 0 and pwm = 0, with no next_sample while low. Reassert it and check the next_sample pulse after exactly 1022 cycles, with duty and err preserved.
- Integration: `nco` with fcw = 0x010000 driven by next_sample. The DAC must latch addresses 0, 1, 2… in consecutive windows, with exactly one request per window and no skipped or duplicated samples over 512 windows.
